// File: rtl/display_scan_mux.sv
// Scans four hex digits onto a common-anode 7-segment display, with a frame-aligned LOAD/ACK
// update handshake and a static "E." error override. All pins are registered.
module display_scan_mux #(
    parameter int unsigned CLK_HZ    = 50_000_000,
    parameter int unsigned SCAN_HZ   = 1_000,
    parameter int unsigned BLANK_CYC = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] DATA,
    input  logic [3:0]  DP_IN,
    input  logic [3:0]  BLANK_IN,
    input  logic        LOAD,
    output logic        ACK,
    output logic        PEND,
    input  logic        ERRO,
    output logic        D1,
    output logic        D2,
    output logic        D3,
    output logic        D4,
    output logic        SEG_A,
    output logic        SEG_B,
    output logic        SEG_C,
    output logic        SEG_D,
    output logic        SEG_E,
    output logic        SEG_F,
    output logic        SEG_G,
    output logic        SEG_P
);

    localparam int unsigned DIV   = CLK_HZ / SCAN_HZ;
    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);
    // Pin encoding {p,g,f,e,d,c,b,a}, active-low: "E." lights a,d,e,f,g,p
    localparam logic [7:0] SEG_ERR = 8'b0000_0110;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic             pend_q, pend_d;
    logic [15:0]      pnd_data_q, pnd_data_d;
    logic [3:0]       pnd_dp_q, pnd_dp_d;
    logic [3:0]       pnd_blank_q, pnd_blank_d;
    logic [15:0]      act_data_q, act_data_d;
    logic [3:0]       act_dp_q, act_dp_d;
    logic [3:0]       act_blank_q, act_blank_d;
    logic             ack_q, ack_d;
    logic [3:0]       dig_q, dig_d;
    logic [7:0]       seg_q, seg_d;

    logic             boundary_c;
    logic [3:0]       nibble_c;
    logic [6:0]       lit_c;

    // Slot counter and digit index; the error override parks both at zero
    always_comb begin
        cnt_d = cnt_q;
        idx_d = idx_q;
        if (ERRO) begin
            cnt_d = '0;
            idx_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign boundary_c = !ERRO && (cnt_q == CNT_LAST) && (idx_q == 2'd3);

    // Pending/active handshake: transfer happens before a same-cycle LOAD is captured
    always_comb begin
        pend_d      = pend_q;
        pnd_data_d  = pnd_data_q;
        pnd_dp_d    = pnd_dp_q;
        pnd_blank_d = pnd_blank_q;
        act_data_d  = act_data_q;
        act_dp_d    = act_dp_q;
        act_blank_d = act_blank_q;
        ack_d       = 1'b0;
        if (boundary_c && pend_q) begin
            act_data_d  = pnd_data_q;
            act_dp_d    = pnd_dp_q;
            act_blank_d = pnd_blank_q;
            ack_d       = 1'b1;
            pend_d      = 1'b0;
        end
        if (LOAD) begin
            pnd_data_d  = DATA;
            pnd_dp_d    = DP_IN;
            pnd_blank_d = BLANK_IN;
            pend_d      = 1'b1;
        end
    end

    assign nibble_c = act_data_q[{idx_q, 2'b00} +: 4];

    // Hex to lit segments {g,f,e,d,c,b,a}, active-high
    always_comb begin
        lit_c = 7'h00;
        case (nibble_c)
            4'h0: lit_c = 7'h3F;
            4'h1: lit_c = 7'h06;
            4'h2: lit_c = 7'h5B;
            4'h3: lit_c = 7'h4F;
            4'h4: lit_c = 7'h66;
            4'h5: lit_c = 7'h6D;
            4'h6: lit_c = 7'h7D;
            4'h7: lit_c = 7'h07;
            4'h8: lit_c = 7'h7F;
            4'h9: lit_c = 7'h6F;
            4'hA: lit_c = 7'h77;
            4'hB: lit_c = 7'h7C;
            4'hC: lit_c = 7'h39;
            4'hD: lit_c = 7'h5E;
            4'hE: lit_c = 7'h79;
            default: lit_c = 7'h71;
        endcase
    end

    // Next pin values from the current scan position
    always_comb begin
        dig_d = 4'hF;
        seg_d = 8'hFF;
        if (ERRO) begin
            dig_d = 4'b1110;
            seg_d = SEG_ERR;
        end else begin
            if (!act_blank_q[idx_q] && (cnt_q >= CNT_BLANK)) begin
                dig_d[idx_q] = 1'b0;
            end
            if (!act_blank_q[idx_q]) begin
                seg_d = ~{act_dp_q[idx_q], lit_c};
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q       <= '0;
            idx_q       <= '0;
            pend_q      <= 1'b0;
            pnd_data_q  <= '0;
            pnd_dp_q    <= '0;
            pnd_blank_q <= 4'hF;
            act_data_q  <= '0;
            act_dp_q    <= '0;
            act_blank_q <= 4'hF;
            ack_q       <= 1'b0;
            dig_q       <= 4'hF;
            seg_q       <= 8'hFF;
        end else begin
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            pend_q      <= pend_d;
            pnd_data_q  <= pnd_data_d;
            pnd_dp_q    <= pnd_dp_d;
            pnd_blank_q <= pnd_blank_d;
            act_data_q  <= act_data_d;
            act_dp_q    <= act_dp_d;
            act_blank_q <= act_blank_d;
            ack_q       <= ack_d;
            dig_q       <= dig_d;
            seg_q       <= seg_d;
        end
    end

    assign ACK   = ack_q;
    assign PEND  = pend_q;
    assign D1    = dig_q[0];
    assign D2    = dig_q[1];
    assign D3    = dig_q[2];
    assign D4    = dig_q[3];
    assign SEG_A = seg_q[0];
    assign SEG_B = seg_q[1];
    assign SEG_C = seg_q[2];
    assign SEG_D = seg_q[3];
    assign SEG_E = seg_q[4];
    assign SEG_F = seg_q[5];
    assign SEG_G = seg_q[6];
    assign SEG_P = seg_q[7];

endmodule

// File: tb/tb_display_scan_mux.sv
// Bench for display_scan_mux: directed scenarios then random traffic, every cycle compared
// against a time-based reference model of the scan, handshake and error override.
module tb_display_scan_mux;

    localparam int DIV   = 4;
    localparam int BLANK = 1;
    localparam int FRAME = 4 * DIV;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [15:0] DATA = '0;
    logic [3:0]  DP_IN = '0;
    logic [3:0]  BLANK_IN = '0;
    logic        LOAD = 1'b0;
    logic        ERRO = 1'b0;
    logic        ACK, PEND;
    logic        D1, D2, D3, D4;
    logic        SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F, SEG_G, SEG_P;

    display_scan_mux #(.CLK_HZ(16), .SCAN_HZ(4), .BLANK_CYC(1)) dut (
        .CLK(CLK), .RST(RST), .DATA(DATA), .DP_IN(DP_IN), .BLANK_IN(BLANK_IN),
        .LOAD(LOAD), .ACK(ACK), .PEND(PEND), .ERRO(ERRO),
        .D1(D1), .D2(D2), .D3(D3), .D4(D4),
        .SEG_A(SEG_A), .SEG_B(SEG_B), .SEG_C(SEG_C), .SEG_D(SEG_D),
        .SEG_E(SEG_E), .SEG_F(SEG_F), .SEG_G(SEG_G), .SEG_P(SEG_P)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad = 0;

    // Reference state: t = cycles since the scan last restarted
    int          t = 0;
    bit          m_pend = 0;
    logic [15:0] m_pdata = '0;
    logic [3:0]  m_pdp = '0;
    logic [3:0]  m_pbl = 4'hF;
    logic [15:0] m_adata = '0;
    logic [3:0]  m_adp = '0;
    logic [3:0]  m_abl = 4'hF;

    string seg_tbl [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                            "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

    function automatic logic [6:0] lit_of(input logic [3:0] v);
        logic [6:0] r;
        string s;
        r = '0;
        s = seg_tbl[v];
        for (int i = 0; i < s.len(); i++) r[int'(s.getc(i)) - 97] = 1'b1;
        return r;
    endfunction

    // One clock: predict from pre-edge model state, advance the model, then compare
    task automatic cyc(input bit rst, input bit ld, input bit er);
        logic [3:0] e_dig;
        logic [7:0] e_seg;
        logic [3:0] o_dig;
        logic [7:0] o_seg;
        bit e_ack;
        int slot, pos;
        RST = rst; LOAD = ld; ERRO = er;
        e_dig = 4'hF; e_seg = 8'hFF; e_ack = 0;
        if (rst) begin
            t = 0; m_pend = 0; m_abl = 4'hF;
        end else if (er) begin
            e_dig = 4'b1110;
            e_seg = 8'b0000_0110;
            if (ld) begin m_pdata = DATA; m_pdp = DP_IN; m_pbl = BLANK_IN; m_pend = 1; end
            t = 0;
        end else begin
            slot = (t / DIV) % 4;
            pos  = t % DIV;
            if (!m_abl[slot] && pos >= BLANK) e_dig[slot] = 1'b0;
            if (!m_abl[slot]) e_seg = ~{m_adp[slot], lit_of(m_adata[slot*4 +: 4])};
            if ((t % FRAME) == FRAME - 1 && m_pend) begin
                e_ack = 1;
                m_adata = m_pdata; m_adp = m_pdp; m_abl = m_pbl; m_pend = 0;
            end
            if (ld) begin m_pdata = DATA; m_pdp = DP_IN; m_pbl = BLANK_IN; m_pend = 1; end
            t++;
        end
        @(posedge CLK);
        #1;
        LOAD = 1'b0;
        o_dig = {D4, D3, D2, D1};
        o_seg = {SEG_P, SEG_G, SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A};
        total++;
        assert (o_dig === e_dig) else begin bad++; $error("FAIL digits t=%0d got %b exp %b", t, o_dig, e_dig); end
        total++;
        assert (o_seg === e_seg) else begin bad++; $error("FAIL segs t=%0d got %b exp %b", t, o_seg, e_seg); end
        total++;
        assert (ACK === e_ack) else begin bad++; $error("FAIL ack t=%0d got %b exp %b", t, ACK, e_ack); end
        total++;
        assert (PEND === m_pend) else begin bad++; $error("FAIL pend t=%0d got %b exp %b", t, PEND, m_pend); end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0);
    endtask

    // Advance until the next edge is a frame boundary
    task automatic to_wrap();
        for (int i = 0; i < FRAME && (t % FRAME) != FRAME - 1; i++) cyc(0, 0, 0);
    endtask

    initial begin
        bit er;
        // Reset and dark display
        cyc(1, 0, 0); cyc(1, 0, 0); cyc(1, 0, 0);
        idle(20);
        // Basic load, ACK at the wrap
        DATA = 16'h4321; DP_IN = 4'h0; BLANK_IN = 4'h0;
        cyc(0, 1, 0);
        idle(2 * FRAME + 3);
        // Two loads within one frame give a single ACK
        to_wrap(); cyc(0, 0, 0);
        DATA = 16'h1111; cyc(0, 1, 0);
        idle(3);
        DATA = 16'hABCD; DP_IN = 4'b1010; cyc(0, 1, 0);
        idle(2 * FRAME);
        // Load on the wrap cycle while pending
        DATA = 16'h5A5A; DP_IN = 4'b0101; cyc(0, 1, 0);
        to_wrap();
        DATA = 16'h0F0F; BLANK_IN = 4'b0100; DP_IN = 4'b0011; cyc(0, 1, 0);
        idle(2 * FRAME + 2);
        // Error override mid-slot, then restart
        BLANK_IN = 4'h0; DATA = 16'h9876;
        to_wrap(); idle(6);
        for (int i = 0; i < 10; i++) cyc(0, 0, 1);
        idle(FRAME + 4);
        // Reset with data pending mid-frame
        to_wrap(); idle(2);
        DATA = 16'hEEEE; cyc(0, 1, 0);
        idle(2);
        cyc(1, 0, 0); cyc(1, 0, 0);
        idle(FRAME + 5);
        DATA = 16'h4321; DP_IN = 4'h0; BLANK_IN = 4'h0;
        cyc(0, 1, 0);
        idle(2 * FRAME);
        // Random traffic
        er = 0;
        for (int i = 0; i < 800; i++) begin
            DATA = 16'($urandom);
            DP_IN = 4'($urandom);
            BLANK_IN = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            if ($urandom_range(0, 29) == 0) er = !er;
            if ($urandom_range(0, 249) == 0) cyc(1, 0, er);
            else cyc(0, $urandom_range(0, 9) == 0, er);
        end
        idle(FRAME);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
